// File: rtl/ili9341_defines.sv
// Shared types and constants for the ILI9341 SPI arbiter.
package ili9341_defines;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    CHECK,
    SETUP,
    PASS,
    GAP
  } ili9341_arb_state_t;

  localparam logic ARB_PORT_CFG = 1'b0;
  localparam logic ARB_PORT_PIX = 1'b1;

endpackage

// File: rtl/arb_down_counter.sv
// Loadable, saturating down-counter with a zero flag.
module arb_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ili9341_spi_arbiter.sv
// Two-port transaction arbiter in front of the ILI9341 SPI byte controller,
// owning the D/C line and enforcing D/C setup and inter-transaction gaps.
module ili9341_spi_arbiter
  import ili9341_defines::*;
#(
  parameter int DC_SETUP_CYCLES = 2,
  parameter int GAP_CYCLES      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_data,
  input  logic       req0_dc,
  input  logic       req0_last,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_dc,
  input  logic       req1_last,
  output logic       spi_valid,
  input  logic       spi_ready,
  output logic [7:0] spi_data,
  output logic       data_commandb,
  output logic [1:0] grant,
  output logic       busy
);

  ili9341_arb_state_t state_reg, state_next;
  logic       sel_reg, sel_next;
  logic [1:0] grant_reg, grant_next;
  logic       dcb_reg, dcb_next;

  logic       setup_load, setup_dec, setup_zero;
  logic [3:0] setup_count;
  logic       gap_load, gap_dec, gap_zero;
  logic [7:0] gap_count;

  logic       sel_valid, sel_dc, sel_last, sel_ready, dc_match, any_valid;
  logic [7:0] sel_data;

  assign sel_valid = (sel_reg == ARB_PORT_PIX) ? req1_valid : req0_valid;
  assign sel_data  = (sel_reg == ARB_PORT_PIX) ? req1_data  : req0_data;
  assign sel_dc    = (sel_reg == ARB_PORT_PIX) ? req1_dc    : req0_dc;
  assign sel_last  = (sel_reg == ARB_PORT_PIX) ? req1_last  : req0_last;
  assign dc_match  = (sel_dc == dcb_reg);
  assign any_valid = req0_valid | req1_valid;

  arb_down_counter #(.WIDTH(4)) u_setup_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (setup_load),
    .load_value(4'(DC_SETUP_CYCLES)),
    .dec       (setup_dec),
    .count     (setup_count),
    .zero      (setup_zero)
  );

  arb_down_counter #(.WIDTH(8)) u_gap_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (gap_load),
    .load_value(8'(GAP_CYCLES)),
    .dec       (gap_dec),
    .count     (gap_count),
    .zero      (gap_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      sel_reg   <= ARB_PORT_CFG;
      grant_reg <= 2'b00;
      dcb_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      grant_reg <= grant_next;
      dcb_reg   <= dcb_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    grant_next = grant_reg;
    dcb_next   = dcb_reg;
    setup_load = 1'b0;
    setup_dec  = 1'b0;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    spi_valid  = 1'b0;
    spi_data   = 8'h00;
    sel_ready  = 1'b0;
    case (state_reg)
      IDLE: if (any_valid) state_next = ARB;
      ARB: begin
        if (req0_valid) begin
          sel_next   = ARB_PORT_CFG;
          grant_next = 2'b01;
          state_next = CHECK;
        end else if (req1_valid) begin
          sel_next   = ARB_PORT_PIX;
          grant_next = 2'b10;
          state_next = CHECK;
        end else begin
          state_next = IDLE;
        end
      end
      CHECK: begin
        if (sel_valid && !dc_match) begin
          dcb_next   = sel_dc;
          setup_load = 1'b1;
          state_next = SETUP;
        end else if (sel_valid) begin
          state_next = PASS;
        end
      end
      // Counter is compared before its decrement lands, hence the "== 1" exit.
      SETUP: begin
        setup_dec = 1'b1;
        if (setup_zero || (setup_count == 4'd1)) state_next = PASS;
      end
      PASS: begin
        spi_valid = sel_valid && dc_match;
        spi_data  = sel_data;
        sel_ready = spi_ready && dc_match;
        if (sel_valid && dc_match && spi_ready && sel_last) begin
          grant_next = 2'b00;
          gap_load   = 1'b1;
          state_next = GAP;
        end else if (sel_valid && !dc_match) begin
          state_next = CHECK;
        end
      end
      GAP: begin
        gap_dec = 1'b1;
        if (gap_zero || (gap_count == 8'd1)) state_next = any_valid ? ARB : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req0_ready    = sel_ready && (sel_reg == ARB_PORT_CFG);
  assign req1_ready    = sel_ready && (sel_reg == ARB_PORT_PIX);
  assign data_commandb = dcb_reg;
  assign grant         = grant_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_ili9341_spi_arbiter.sv
// Directed bench for ili9341_spi_arbiter: transaction-level scoreboard plus literal timing checks.
module tb_ili9341_spi_arbiter;

  localparam int DC_SETUP = 2;
  localparam int GAP      = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       dc;
    logic       last;
  } item_t;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready, req0_dc, req0_last;
  logic [7:0] req0_data;
  logic       req1_valid, req1_ready, req1_dc, req1_last;
  logic [7:0] req1_data;
  logic       spi_valid, spi_ready, data_commandb, busy;
  logic [7:0] spi_data;
  logic [1:0] grant;

  // second instance with zero setup and zero gap
  logic       z0_valid, z0_ready, z0_dc, z0_last;
  logic [7:0] z0_data;
  logic       z1_valid, z1_ready, z1_dc, z1_last;
  logic [7:0] z1_data;
  logic       z_spi_valid, z_spi_ready, z_dcb, z_busy;
  logic [7:0] z_spi_data;
  logic [1:0] z_grant;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic toggle_ready = 1'b0;

  item_t q0[$], q1[$], e0[$], e1[$];
  int    owners[$];
  int    span_of[2];
  int    setup_idle = -1;
  int    gap_run    = 0;

  ili9341_spi_arbiter #(.DC_SETUP_CYCLES(DC_SETUP), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_dc(req0_dc), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_dc(req1_dc), .req1_last(req1_last),
    .spi_valid(spi_valid), .spi_ready(spi_ready), .spi_data(spi_data),
    .data_commandb(data_commandb), .grant(grant), .busy(busy)
  );

  ili9341_spi_arbiter #(.DC_SETUP_CYCLES(0), .GAP_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .req0_valid(z0_valid), .req0_ready(z0_ready), .req0_data(z0_data),
    .req0_dc(z0_dc), .req0_last(z0_last),
    .req1_valid(z1_valid), .req1_ready(z1_ready), .req1_data(z1_data),
    .req1_dc(z1_dc), .req1_last(z1_last),
    .spi_valid(z_spi_valid), .spi_ready(z_spi_ready), .spi_data(z_spi_data),
    .data_commandb(z_dcb), .grant(z_grant), .busy(z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int p, input logic [7:0] d, input logic dc, input logic last);
    item_t it;
    it = '{data: d, dc: dc, last: last};
    if (p == 0) begin q0.push_back(it); e0.push_back(it); end
    else        begin q1.push_back(it); e1.push_back(it); end
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && q0.size() == 0 && q1.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // requester drivers: present queue head, pop on an observed handshake
  initial begin : drv0
    item_t it;
    logic  acc;
    req0_valid = 0; req0_data = 0; req0_dc = 0; req0_last = 0;
    forever begin
      @(negedge clk); acc = req0_valid && req0_ready;
      @(posedge clk); #1;
      if (acc && q0.size() > 0) it = q0.pop_front();
      if (q0.size() > 0) begin
        it = q0[0];
        req0_valid = 1; req0_data = it.data; req0_dc = it.dc; req0_last = it.last;
      end else req0_valid = 0;
    end
  end

  initial begin : drv1
    item_t it;
    logic  acc;
    req1_valid = 0; req1_data = 0; req1_dc = 0; req1_last = 0;
    forever begin
      @(negedge clk); acc = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (acc && q1.size() > 0) it = q1.pop_front();
      if (q1.size() > 0) begin
        it = q1[0];
        req1_valid = 1; req1_data = it.data; req1_dc = it.dc; req1_last = it.last;
      end else req1_valid = 0;
    end
  end

  initial begin : drv_ready
    spi_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      spi_ready = toggle_ready ? ~spi_ready : 1'b1;
    end
  end

  // compare process: transaction-level model of what must appear on the SPI side
  initial begin : monitor
    logic  in_txn, stall_prev, prev_dcb, gap_counting, p;
    logic [7:0] stall_data;
    int    owner, txn_first, last_end, dc_change, last_xfer;
    item_t e;
    in_txn = 0; stall_prev = 0; prev_dcb = 0; gap_counting = 0;
    stall_data = 0; owner = 0; txn_first = 0; last_end = -1000; dc_change = -1000; last_xfer = -1000;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_txn = 0; stall_prev = 0; prev_dcb = 0; gap_counting = 0;
        last_end = -1000; dc_change = -1000;
      end else begin
        if (data_commandb !== prev_dcb) begin
          chk("dc_change_while_valid", 32'(spi_valid), 32'd0);
          dc_change = cyc;
        end
        if (req0_ready || req1_ready) begin
          chk("ready_onehot", 32'(req0_ready && req1_ready), 32'd0);
          chk("ready_needs_spi_ready", 32'(spi_ready), 32'd1);
        end
        if (req0_ready) chk("ready0_grant", 32'(grant), 32'd1);
        if (req1_ready) chk("ready1_grant", 32'(grant), 32'd2);
        if (!busy) chk("idle_outputs", 32'({grant, spi_valid}), 32'd0);
        if (stall_prev) chk("stall_hold", 32'({spi_valid, spi_data}), 32'({1'b1, stall_data}));
        p = grant[1];
        if (spi_valid) begin
          chk("valid_grant_onehot", 32'(grant == 2'b01 || grant == 2'b10), 32'd1);
          chk("pass_data", 32'(spi_data), 32'(p ? req1_data : req0_data));
          chk("pass_dc", 32'(p ? req1_dc : req0_dc), 32'(data_commandb));
        end
        if (spi_valid && spi_ready) begin
          chk("xfer_ready", 32'(p ? req1_ready : req0_ready), 32'd1);
          if ((p ? e1.size() : e0.size()) == 0) begin
            chk("xfer_unexpected", 32'(spi_data), 32'hFFFF_FFFF);
            e = '0;
          end else begin
            e = p ? e1.pop_front() : e0.pop_front();
            chk("xfer_byte", 32'({data_commandb, spi_data}), 32'({e.dc, e.data}));
          end
          if (!in_txn) begin
            in_txn = 1; owner = int'(p); txn_first = cyc; owners.push_back(int'(p));
            chk("gap_before_txn", 32'((cyc - last_end) > GAP), 32'd1);
          end else begin
            chk("txn_not_split", 32'(p), 32'(owner));
          end
          chk("dc_setup_time", 32'((cyc - dc_change) >= DC_SETUP), 32'd1);
          if (dc_change > last_xfer) setup_idle = cyc - dc_change;
          last_xfer = cyc;
          if (e.last) begin
            in_txn = 0; last_end = cyc; span_of[int'(p)] = cyc - txn_first;
            gap_counting = 1; gap_run = 0;
          end
        end else if (gap_counting) begin
          if (busy && grant == 2'b00) gap_run++;
          else gap_counting = 0;
        end
        stall_prev = spi_valid && !spi_ready;
        stall_data = spi_data;
        prev_dcb   = data_commandb;
      end
    end
  end

  initial begin : main
    logic found;
    rst = 1'b0;
    z0_valid = 0; z0_data = 0; z0_dc = 0; z0_last = 0;
    z1_valid = 0; z1_data = 0; z1_dc = 0; z1_last = 0;
    z_spi_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({grant, busy, spi_valid, req0_ready, req1_ready, data_commandb, spi_data}), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // command 0x2A followed by four parameters
    push(0, 8'h2A, 0, 0);
    push(0, 8'h00, 1, 0); push(0, 8'h00, 1, 0); push(0, 8'h00, 1, 0);
    push(0, 8'h1F, 1, 1);
    wait_idle("t1_done", 200);
    chk("t1_owner", 32'(owners[0]), 32'd0);
    chk("t1_setup_idle", 32'(setup_idle), 32'd2);
    chk("t1_gap_cycles", 32'(gap_run), 32'd4);

    // simultaneous requests: port 0 wins
    push(0, 8'h2B, 0, 0); push(0, 8'h00, 1, 1);
    push(1, 8'h2C, 0, 0); push(1, 8'hAA, 1, 1);
    wait_idle("t2_done", 200);
    chk("t2_first_owner", 32'(owners[1]), 32'd0);
    chk("t2_second_owner", 32'(owners[2]), 32'd1);

    // 64-byte pixel burst, port 0 arrives mid-burst
    for (int i = 0; i < 64; i++) push(1, 8'(i * 3 + 1), 1, (i == 63));
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (e1.size() <= 54) begin found = 1; break; end
    end
    chk("t3_reach_byte10", 32'(found), 32'd1);
    #1 push(0, 8'h2A, 0, 1);
    wait_idle("t3_done", 400);
    chk("t3_burst_owner", 32'(owners[3]), 32'd1);
    chk("t3_burst_contiguous", 32'(span_of[1]), 32'd63);
    chk("t3_cfg_after_gap", 32'(owners[4]), 32'd0);

    // spi_ready toggling
    toggle_ready = 1'b1;
    push(0, 8'h36, 0, 0); push(0, 8'h48, 1, 1);
    push(1, 8'h11, 1, 0); push(1, 8'h22, 1, 0); push(1, 8'h33, 1, 0); push(1, 8'h44, 1, 1);
    wait_idle("t4_done", 400);
    toggle_ready = 1'b0;
    chk("t4_owners", 32'({owners[5][1:0], owners[6][1:0]}), 32'h1);
    chk("t4_all_bytes", 32'(e0.size() + e1.size()), 32'd0);

    // asynchronous reset during byte 3 of a burst
    for (int i = 0; i < 8; i++) push(1, 8'(8'hC0 + i), 1, (i == 7));
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (e1.size() == 6) begin found = 1; break; end
    end
    chk("t5_reach_byte3", 32'(found), 32'd1);
    #2 rst = 1'b0;
    q1.delete(); e1.delete();
    #1 chk("t5_async_reset",
           32'({grant, busy, spi_valid, req0_ready, req1_ready, data_commandb, spi_data}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_grant_after_reset", 32'({grant, busy, spi_valid}), 32'd0);
    end

    // zero setup / zero gap instance: one command byte, one GAP cycle, then IDLE
    @(posedge clk); #1;
    z0_valid = 1; z0_data = 8'h29; z0_dc = 0; z0_last = 1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (z_spi_valid) begin found = 1; break; end
    end
    chk("t6_xfer_seen", 32'(found), 32'd1);
    chk("t6_xfer", 32'({z_spi_data, z0_ready, z_grant}), 32'({8'h29, 1'b1, 2'b01}));
    @(posedge clk); #1 z0_valid = 0;
    @(negedge clk);
    chk("t6_gap_cycle", 32'({z_busy, z_grant, z_spi_valid}), 32'({1'b1, 2'b00, 1'b0}));
    @(negedge clk);
    chk("t6_back_idle", 32'({z_busy, z_grant}), 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(e0.size() + e1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
